debug_run_ctrl: RTL

DEBUG_RUN_CTRL -- requirements
Module: debug_run_ctrl

---
 rtl/nese_dbg_pkg.sv | 20 ++
 rtl/debug_run_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/nese_dbg_pkg.sv
// Shared encodings for the debug run controller: command opcodes, FSM states, datapath width.
package nese_dbg_pkg;

    localparam int DBG_W = 16;

    typedef enum logic [1:0] {
        OP_RUN    = 2'd0,
        OP_HALT   = 2'd1,
        OP_STEP   = 2'd2,
        OP_RUN_TO = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2,
        ST_RUNTO    = 2'd3
    } dbg_state_e;

endpackage

// File: rtl/debug_run_ctrl.sv
// Debug run/halt/step/run-to controller driving the clk_int_matcher that gates the CPU clock.
// Optional completion counter enabled by defining DBG_HIT_COUNT_EN.
module debug_run_ctrl
    import nese_dbg_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [DBG_W-1:0] cmd_arg,
    output logic             cmd_ready,
    output logic             cmd_err,
    input  logic [DBG_W-1:0] cpu_addr,
    output logic             mtch_active,
    output logic [DBG_W-1:0] mtch_int_a,
    output logic [DBG_W-1:0] mtch_int_b,
    input  logic             mtch_match,
    output logic             halted,
    output logic             done,
    output logic [DBG_W-1:0] hit_count
);

    dbg_state_e       state, state_d;
    cmd_op_e          op;
    logic [DBG_W-1:0] step_cnt, step_cnt_d;
    logic [DBG_W-1:0] int_b_d;
    logic             done_d, err_d;

    assign op        = cmd_op_e'(cmd_op);
    assign cmd_ready = 1'b1;

    // A matcher hit takes priority over a same-cycle HALT so the completion is still reported.
    always_comb begin
        state_d    = state;
        step_cnt_d = step_cnt;
        int_b_d    = mtch_int_b;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state)
            ST_HALTED: begin
                if (cmd_valid) begin
                    case (op)
                        OP_RUN: state_d = ST_RUNNING;
                        OP_STEP: begin
                            if (cmd_arg != '0) begin
                                state_d    = ST_STEPPING;
                                step_cnt_d = '0;
                                int_b_d    = cmd_arg;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        OP_RUN_TO: begin
                            state_d = ST_RUNTO;
                            int_b_d = cmd_arg;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUNNING: begin
                if (cmd_valid) begin
                    if (op == OP_HALT) state_d = ST_HALTED;
                    else               err_d   = 1'b1;
                end
            end
            ST_STEPPING: begin
                if (mtch_match) begin
                    state_d = ST_HALTED;
                    done_d  = 1'b1;
                end else if (cmd_valid && op == OP_HALT) begin
                    state_d = ST_HALTED;
                end else begin
                    step_cnt_d = step_cnt + 1'b1;
                    err_d      = cmd_valid;
                end
            end
            default: begin
                if (mtch_match) begin
                    state_d = ST_HALTED;
                    done_d  = 1'b1;
                end else if (cmd_valid && op == OP_HALT) begin
                    state_d = ST_HALTED;
                end else begin
                    err_d = cmd_valid;
                end
            end
        endcase
        // Halted means a forced 0==0 match, so both compare operands return to zero.
        if (state_d == ST_HALTED) begin
            step_cnt_d = '0;
            int_b_d    = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= ST_HALTED;
            step_cnt    <= '0;
            mtch_int_b  <= '0;
            mtch_active <= 1'b1;
            halted      <= 1'b1;
            done        <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state       <= state_d;
            step_cnt    <= step_cnt_d;
            mtch_int_b  <= int_b_d;
            mtch_active <= (state_d != ST_RUNNING);
            halted      <= (state_d == ST_HALTED);
            done        <= done_d;
            cmd_err     <= err_d;
        end
    end

    // In RUNTO the live address bus is compared directly so a hit is seen in the same cycle.
    always_comb begin
        mtch_int_a = '0;
        case (state)
            ST_STEPPING: mtch_int_a = step_cnt;
            ST_RUNTO:    mtch_int_a = cpu_addr;
            default:     mtch_int_a = '0;
        endcase
    end

`ifdef DBG_HIT_COUNT_EN
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
        end else if (done_d && hit_count != {DBG_W{1'b1}}) begin
            hit_count <= hit_count + 1'b1;
        end
    end
`else
    assign hit_count = '0;
`endif

endmodule
